imem_ctrl: RTL and testbench
============================

// Module: imem_ctrl
// PURPOSE
//   Parametrised single-port instruction/data memory with valid/ready request and response channels,
//   programmable wait states, byte-strobe writes and range/alignment error reporting. Next generation
//   of the core's combinational word memory; sits between the multicycle core's memory FSM and storage.
// PARAMETERS
//   DATA_WIDTH   32                            word width, 32 or 64; BYTES = DATA_WIDTH/8
//   SIZE_WORDS   32768                         depth in words, need not be a power of two
//   WAIT_STATES  1                             extra cycles between accept and response, 0..15
//   MEMFILE      "instructions/default.hex"    $readmemh image, overridable by +MEMFILE= (sim only)
// PORTS
//   clk        in   1            rising-edge clock
//   reset      in   1            asynchronous, active-high reset
//   req_valid  in   1            request present
//   req_ready  out  1            request accepted when valid & ready
//   req_we     in   1            1 = write, 0 = read
//   req_addr   in   32           byte address
//   req_wdata  in   DATA_WIDTH   write data
//   req_wstrb  in   BYTES        byte enables, bit i -> byte lane i
//   rsp_valid  out  1            response present, held until rsp_ready
//   rsp_ready  in   1            consumer accepts response
//   rsp_rdata  out  DATA_WIDTH   read data; 0 for writes and errored requests
//   rsp_err    out  1            request faulted (out of range or misaligned)
// BEHAVIOUR
//   - Reset (async): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
//     Array contents are NOT reset. Reset mid-transaction drops the pending response; a write already
//     committed at accept stays in the array.
//   - word index = req_addr >> log2(BYTES); out-of-range when index >= SIZE_WORDS.
//   - FSM IDLE: req_ready=1. On accept: latch fault flag, read word; write committed on the accept edge
//     (lanes with wstrb=1 only, none if faulted). Go WAIT with counter=WAIT_STATES-1, or RESP if WAIT_STATES=0.
//   - WAIT: req_ready=0; decrement counter; at 0 go RESP. RESP: rsp_valid=1, outputs stable;
//     on rsp_ready go IDLE (req_ready rises next cycle; no same-cycle back-to-back).
//   - Latency accept->rsp_valid = WAIT_STATES+1 cycles. rsp_rdata is pre-write data latched at accept,
//     forced 0 for writes and faults. req_* ignored outside IDLE.
//   - Boundary: last word (SIZE_WORDS-1) is legal; index SIZE_WORDS faults; addr bits above index ignored
//     only for range check, never wrapped. wstrb=0 write is a legal no-op with rsp_err=0.
// CONFIGURATION
//   MEM_MISALIGN_FAULT_EN defined: req_addr[log2(BYTES)-1:0] != 0 sets rsp_err, suppresses write,
//     rsp_rdata=0.
//   Undefined: low address bits ignored (access truncated to containing word), rsp_err only for range.
// STRUCTURE
//   - Package mem_pkg: state enum {IDLE, WAIT, RESP}, WAIT_CNT_W=4 constant, fault-reason encodings.
//   - Sub-module imem_array: storage, combinational read, per-byte-lane synchronous write, MEMFILE load;
//     imem_ctrl holds FSM, counter, fault logic and response registers.
// TESTING
//   1. Reset asserted mid-WAIT -> rsp_valid=0 immediately, req_ready=1 after release, no response emitted.
//   2. WAIT_STATES=1: read 0x0000_0010 (preloaded 0xDEADBEEF) -> rsp_valid 2 cycles after accept, data
//      0xDEADBEEF, err=0; hold rsp_ready=0 3 cycles -> outputs stable.
//   3. Write 0x1122_3344 wstrb=4'b0101 to 0x20 over 0xAAAA_AAAA, read back -> 0xAA22_AA44.
//   4. SIZE_WORDS=1000: read addr 999*4 -> err=0; addr 1000*4 -> err=1, rdata=0; write 1000*4 -> array unchanged.
//   5. Misaligned read 0x0000_0012: with MEM_MISALIGN_FAULT_EN -> err=1, rdata=0; without -> word 0x10 data, err=0.
//   6. WAIT_STATES=0 and DATA_WIDTH=64: 64-bit write/read at 0x08 -> 1-cycle latency, full 64-bit data returned.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the instruction/data memory controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

  // Controller phases: take a request, count wait states, present the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wide enough for the 0..15 wait-state range.
  localparam int WAIT_CNT_W = 4;

  // Reason a request faulted; misalignment takes precedence over range.
  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_RANGE    = 2'd1,
    FAULT_MISALIGN = 2'd2
  } fault_t;

endpackage

// File: rtl/imem_array.sv
// Word-organised storage with a combinational read port and a byte-lane write port.
// Latency: read is combinational; a write lands on the clock edge where we=1.
// Backpressure: none, always ready; contents are never reset.
module imem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WORDS = 32768,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int IDX_W = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BYTES-1:0]      wstrb,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [SIZE_WORDS];

  // Read returns the word as it is before any write on the coming edge.
  always_comb begin
    rdata = mem[idx];
  end

  // Update only the byte lanes whose strobe is set.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) begin
          mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// Memory controller: valid/ready request -> programmable wait -> held response, with range/alignment faults.
// Latency: accept to rsp_valid is WAIT_STATES+1 cycles; one request in flight, no same-cycle back-to-back.
// Backpressure: req_ready only in IDLE; rsp_valid and its data hold until rsp_ready.
// Optional: define MEM_MISALIGN_FAULT_EN to fault on byte addresses that are not word aligned.
module imem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SIZE_WORDS  = 32768,
  parameter int WAIT_STATES = 1,
  localparam int BYTES = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BYTES-1:0]      req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1;
  // Counter load so that the last WAIT cycle sees zero.
  localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_t                state, state_nxt;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [31:0]           word_idx;
  logic                  misaligned;
  fault_t                fault_reason;
  logic                  fault;
  logic                  accept;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Full word index is range-checked as is; upper address bits are never wrapped away.
  always_comb begin
    word_idx = req_addr >> OFF_W;
`ifdef MEM_MISALIGN_FAULT_EN
    misaligned = |req_addr[OFF_W-1:0];
`else
    misaligned = 1'b0;
`endif
    fault_reason = FAULT_NONE;
    if (misaligned) begin
      fault_reason = FAULT_MISALIGN;
    end else if (word_idx >= 32'(SIZE_WORDS)) begin
      fault_reason = FAULT_RANGE;
    end
    fault  = (fault_reason != FAULT_NONE);
    accept = req_valid && req_ready;
  end

  imem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIZE_WORDS (SIZE_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (accept && req_we && !fault),
    .idx   (word_idx[IDX_W-1:0]),
    .wdata (req_wdata),
    .wstrb (req_wstrb),
    .rdata (arr_rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wait-state counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - WAIT_CNT_W'(1);
    end
  end

  // Response captured at accept: pre-write word for clean reads, zero for writes and faults.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= fault;
      rsp_rdata <= (req_we || fault) ? '0 : arr_rdata;
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: directed vectors, reset corner cases, 64-bit/zero-wait instance, random vs model.
// Latency: n/a.
// Backpressure: responses are held for random cycles before rsp_ready.
module tb_imem_ctrl;

`ifdef MEM_MISALIGN_FAULT_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  localparam int NWORDS = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_wstrb;

  logic        w_req_valid, w_req_ready, w_req_we, w_rsp_valid, w_rsp_ready, w_rsp_err;
  logic [31:0] w_req_addr;
  logic [63:0] w_req_wdata, w_rsp_rdata;
  logic [7:0]  w_req_wstrb;

  imem_ctrl #(.DATA_WIDTH(32), .SIZE_WORDS(NWORDS), .WAIT_STATES(1)) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  imem_ctrl #(.DATA_WIDTH(64), .SIZE_WORDS(16), .WAIT_STATES(0)) dut64 (
    .clk(clk), .reset(rst),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(w_req_we), .req_addr(w_req_addr),
    .req_wdata(w_req_wdata), .req_wstrb(w_req_wstrb),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_rdata(w_rsp_rdata), .rsp_err(w_rsp_err)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Present a request for one edge (caller guarantees IDLE), then drive a junk write that must be ignored.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_wstrb = 4'hf;
  endtask

  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int hold, output logic [31:0] rd, output logic er, output int lat);
    issue(we, a, d, s);
    lat = 0; rd = '0; er = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 64'(rsp_valid), 64'(1));
    end else begin
      rd = rsp_rdata; er = rsp_err;
      chk("req_ready_busy", 64'(req_ready), 64'(0));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_stable", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({1'b1, er, rd}));
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
  endtask

  task automatic txn64(input logic we, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                       output logic [63:0] rd, output logic er, output int lat);
    w_req_valid = 1'b1; w_req_we = we; w_req_addr = a; w_req_wdata = d; w_req_wstrb = s;
    @(posedge clk); #1;
    w_req_valid = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (w_rsp_valid) break;
    end
    rd = w_rsp_rdata; er = w_rsp_err;
    w_rsp_ready = 1'b1;
    @(posedge clk); #1;
    w_rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        tbl [14];
  logic [31:0] model [NWORDS];
  logic [31:0] rd, addr, wd, exp_rd;
  logic [63:0] rd64;
  logic [3:0]  st;
  logic        er, we, fault;
  int          lat, k, widx, hold;

  initial begin
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
    w_req_valid = 0; w_req_we = 0; w_req_addr = 0; w_req_wdata = 0; w_req_wstrb = 0; w_rsp_ready = 0;

    // Reset values
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    chk("rst64_req_ready", 64'(w_req_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors: {we, addr, wdata, strb, hold, exp_rdata, exp_err}
    tbl[0]  = '{1'b1, 32'h10,        32'hDEADBEEF, 4'hf, 0, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,        32'h0,        4'h0, 3, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h20,        32'hAAAAAAAA, 4'hf, 0, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 32'h20,        32'h11223344, 4'h5, 1, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h20,        32'h0,        4'h0, 0, 32'hAA22AA44, 1'b0};
    tbl[5]  = '{1'b1, 32'd3996,      32'h55667788, 4'hf, 0, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 32'd3996,      32'h0,        4'h0, 0, 32'h55667788, 1'b0};
    tbl[7]  = '{1'b0, 32'd4000,      32'h0,        4'h0, 2, 32'h0,        1'b1};
    tbl[8]  = '{1'b1, 32'd4000,      32'hFFFFFFFF, 4'hf, 0, 32'h0,        1'b1};
    tbl[9]  = '{1'b0, 32'd3996,      32'h0,        4'h0, 0, 32'h55667788, 1'b0};
    tbl[10] = '{1'b1, 32'h20,        32'h0,        4'h0, 0, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 32'h20,        32'h0,        4'h0, 0, 32'hAA22AA44, 1'b0};
    tbl[12] = '{1'b0, 32'h12,        32'h0,        4'h0, 0, MIS_EN ? 32'h0 : 32'hDEADBEEF, MIS_EN};
    tbl[13] = '{1'b0, 32'h80000010,  32'h0,        4'h0, 0, 32'h0,        1'b1};
    for (int i = 0; i < 14; i++) begin
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].strb, tbl[i].hold, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(tbl[i].exp_rd));
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(tbl[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(2));
    end

    // Reset during WAIT: committed write survives, no response appears
    issue(1'b1, 32'h30, 32'hCAFEF00D, 4'hf);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstwait_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rstwait_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstwait_no_rsp", 64'(rsp_valid), 64'(0));
    end
    chk("rstwait_ready_after", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    txn(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat);
    chk("rstwait_write_kept", 64'(rd), 64'(32'hCAFEF00D));

    // Reset while a response is presented drops it immediately
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    req_valid = 1'b0;
    lat = 0;
    while (lat < 20 && !rsp_valid) begin
      @(negedge clk);
      lat++;
    end
    chk("rstresp_seen", 64'(rsp_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("rstresp_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rstresp_rdata", 64'(rsp_rdata), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // 64-bit, zero wait states
    txn64(1'b1, 32'h08, 64'h0123456789ABCDEF, 8'hff, rd64, er, lat);
    chk("w64_wr_rdata", rd64, 64'h0);
    chk("w64_wr_latency", 64'(lat), 64'(1));
    txn64(1'b0, 32'h08, 64'h0, 8'h00, rd64, er, lat);
    chk("w64_rd_rdata", rd64, 64'h0123456789ABCDEF);
    chk("w64_rd_err", 64'(er), 64'(0));
    chk("w64_rd_latency", 64'(lat), 64'(1));

    // Random: fill the address pool, then mixed traffic against the model
    for (int i = 0; i < 26; i++) begin
      widx = (i < 16) ? i : 974 + i;
      wd = $urandom;
      txn(1'b1, 32'(widx) << 2, wd, 4'hf, 0, rd, er, lat);
      model[widx] = wd;
    end
    for (int n = 0; n < 160; n++) begin
      k = $urandom_range(0, 29);
      widx = (k < 16) ? k : 974 + k;
      addr = 32'(widx) << 2;
      if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) addr[31] = 1'b1;
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      hold = $urandom_range(0, 2);
      fault = ((addr >> 2) >= 32'(NWORDS)) || (MIS_EN && addr[1:0] != 2'b00);
      exp_rd = (we || fault) ? 32'h0 : model[addr >> 2];
      txn(we, addr, wd, st, hold, rd, er, lat);
      chk($sformatf("rnd%0d_rdata", n), 64'(rd), 64'(exp_rd));
      chk($sformatf("rnd%0d_err", n), 64'(er), 64'(fault));
      chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'(2));
      if (we && !fault) begin
        for (int b = 0; b < 4; b++) begin
          if (st[b]) model[addr >> 2][b*8 +: 8] = wd[b*8 +: 8];
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
